// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states and line-level constants.
package uart_pkg;

    localparam int   DataBits   = 8;
    localparam logic IdleLevel  = 1'b1;
    localparam logic StartLevel = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Handshake between the byte FIFO read side and the UART transmitter.
// master = transmitter (issues pops), slave = FIFO (supplies bytes).
interface fifo_uart_tx_if;

    logic [7:0] fByte;
    logic       fEmpty;
    logic       fPop;

    modport master (input fByte, input fEmpty, output fPop);
    modport slave  (output fByte, output fEmpty, input fPop);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts ClocksPerBit clocks per bit and ticks on the last one.
// Shared with the future receiver.
module uart_bit_timer #(
    parameter int ClocksPerBit = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_restart,
    output logic o_bit_done
);

    localparam int              CntW    = $clog2(ClocksPerBit);
    localparam logic [CntW-1:0] LastCnt = CntW'(ClocksPerBit - 1);

    logic [CntW-1:0] r_cnt;

    // Clock counter: cleared on restart, wraps to zero at the bit boundary.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == LastCnt)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bit_done = (r_cnt == LastCnt) && !i_restart;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one byte, frames it (start, 8 data LSB first,
// optional parity, 1 or 2 stop bits) and shifts it out on txLine.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int ClocksPerBit = 16,
    parameter int ParityEnable = 0,
    parameter int ParityOdd    = 0,
    parameter int StopBits     = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    fifo_uart_tx_if.master fifo,
    output logic           txLine,
    output logic           txBusy
);

    localparam logic       ParityInv = (ParityOdd != 0);
    localparam logic [2:0] LastData  = 3'(DataBits - 1);
    localparam logic [2:0] LastStop  = 3'(StopBits - 1);

    tx_state_e  r_state, w_state_n;
    logic       r_pop, w_pop_n;
    logic       r_line, w_line_n;
    logic       r_busy;
    logic [7:0] r_shift, w_shift_n;
    logic [2:0] r_idx, w_idx_n;
    logic       w_bit_done;
    logic       w_restart;
    logic       w_pop_cond;

    // Hold the bit timer cleared until the start bit begins.
    assign w_restart = (r_state == IDLE) || (r_state == FETCH) || (r_state == LATCH);

    uart_bit_timer #(
        .ClocksPerBit (ClocksPerBit)
    ) u_bit_timer (
        .clock      (clock),
        .reset      (reset),
        .i_restart  (w_restart),
        .o_bit_done (w_bit_done)
    );

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        w_state_n  = r_state;
        w_pop_n    = 1'b0;
        w_line_n   = r_line;
        w_shift_n  = r_shift;
        w_idx_n    = r_idx;
        w_pop_cond = enable && !fifo.fEmpty;

        case (r_state)
            IDLE: begin
                w_line_n = IdleLevel;
                if (w_pop_cond) begin
                    w_pop_n   = 1'b1;
                    w_state_n = FETCH;
                end
            end
            // FIFO samples the pop on this edge; its byte is valid next cycle.
            FETCH: w_state_n = LATCH;
            LATCH: begin
                w_shift_n = fifo.fByte;
                w_line_n  = StartLevel;
                w_state_n = START;
            end
            START: begin
                if (w_bit_done) begin
                    w_state_n = DATA;
                    w_line_n  = r_shift[0];
                    w_idx_n   = '0;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    if (r_idx == LastData) begin
                        w_idx_n = '0;
                        if (ParityEnable != 0) begin
                            w_state_n = PARITY;
                            w_line_n  = (^r_shift) ^ ParityInv;
                        end else begin
                            w_state_n = STOP;
                            w_line_n  = IdleLevel;
                        end
                    end else begin
                        w_idx_n  = r_idx + 3'd1;
                        w_line_n = r_shift[r_idx + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (w_bit_done) begin
                    w_state_n = STOP;
                    w_line_n  = IdleLevel;
                    w_idx_n   = '0;
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    if (r_idx == LastStop) begin
                        // Last stop edge doubles as the pop edge for back-to-back frames.
                        if (w_pop_cond) begin
                            w_pop_n   = 1'b1;
                            w_state_n = FETCH;
                        end else begin
                            w_state_n = IDLE;
                        end
                    end else begin
                        w_idx_n = r_idx + 3'd1;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // State and output registers; reset forces an idle line immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pop   <= 1'b0;
            r_line  <= IdleLevel;
            r_busy  <= 1'b0;
            r_shift <= '0;
            r_idx   <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            r_state <= w_state_n;
            r_pop   <= w_pop_n;
            r_line  <= w_line_n;
            r_busy  <= (w_state_n != IDLE);
            r_shift <= w_shift_n;
            r_idx   <= w_idx_n;
        end
    end

    assign fifo.fPop = r_pop;
    assign txLine    = r_line;
    assign txBusy    = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity, even parity, odd parity)
// sharing one FIFO model; expected line levels are queued when bytes are pushed.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] en    = 3'b000;
    logic [2:0] pop;
    logic [2:0] line;
    logic [2:0] busy;
    logic [7:0] fbyte [3] = '{default: 8'h00};
    logic [7:0] mem [64];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic       fifo_empty;
    int         sel = 0;
    int         pop_cnt [3] = '{0, 0, 0};
    int         total = 0;
    int         bad = 0;
    logic       sb [$];

    always #5 clock = ~clock;

    assign fifo_empty = (wr_cnt == rd_cnt);

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fifo_uart_tx_if u_if ();
        assign u_if.fByte  = fbyte[g];
        assign u_if.fEmpty = (sel != g) || fifo_empty;
        assign pop[g]      = u_if.fPop;

        fifo_uart_tx #(
            .ClocksPerBit (CPB),
            .ParityEnable ((g != 0) ? 1 : 0),
            .ParityOdd    ((g == 2) ? 1 : 0),
            .StopBits     (1)
        ) u_dut (
            .clock  (clock),
            .reset  (reset),
            .enable (en[g]),
            .fifo   (u_if.master),
            .txLine (line[g]),
            .txBusy (busy[g])
        );
    end

    // FIFO model: registered read port, byte updates on the edge that samples pop.
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (pop[i]) pop_cnt[i] <= pop_cnt[i] + 1;
        end
        if (pop[sel] && (wr_cnt != rd_cnt)) begin
            fbyte[sel] <= mem[rd_cnt % 64];
            rd_cnt     <= rd_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic int frame_bits();
        return (sel != 0) ? 11 : 10;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        mem[wr_cnt % 64] = b;
        wr_cnt = wr_cnt + 1;
        sb.push_back(1'b0);
        for (int i = 0; i < 8; i++) sb.push_back(b[i]);
        if (sel != 0) sb.push_back((^b) ^ (sel == 2));
        sb.push_back(1'b1);
    endtask

    // Waits for the start bit, then compares every clock of each bit against the scoreboard.
    task automatic rx_frame(input string tag, input int drop_at);
        int             n;
        int             nbits;
        logic           exp_bit;
        logic [CPB-1:0] smp;
        nbits = frame_bits();
        n = 0;
        while (line[sel] !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (line[sel] !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL %s start timeout: line=%b after %0d cycles, need 0", tag, line[sel], n);
            for (int i = 0; i < nbits; i++) void'(sb.pop_front());
            return;
        end
        for (int b = 0; b < nbits; b++) begin
            exp_bit = sb.pop_front();
            for (int s = 0; s < CPB; s++) begin
                if (s > 0 || b > 0) @(negedge clock);
                smp[s] = line[sel];
                if (b * CPB + s == drop_at) en[sel] = 1'b0;
            end
            total++;
            if (smp !== {CPB{exp_bit}}) begin
                bad++;
                $display("FAIL %s bit%0d: line=%b need %b", tag, b, smp, {CPB{exp_bit}});
            end
        end
    endtask

    task automatic check_busy_falls(input string tag);
        total++;
        if (busy[sel] !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_last_stop: got %b need 1", tag, busy[sel]);
        end
        @(negedge clock);
        total++;
        if (busy[sel] !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_after_frame: got %b need 0", tag, busy[sel]);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        en  = 3'b001;
        push_byte(8'hA5);
        #2 reset = 1'b0;
        #1;
        total++;
        if (line !== 3'b111 || pop !== 3'b000 || busy !== 3'b000) begin
            bad++;
            $display("FAIL reset_async: line=%b pop=%b busy=%b need 111 000 000", line, pop, busy);
        end
        repeat (6) begin
            @(negedge clock);
            total++;
            if ({line[0], pop[0], busy[0]} !== 3'b100) begin
                bad++;
                $display("FAIL reset_hold: line/pop/busy=%b need 100", {line[0], pop[0], busy[0]});
            end
        end
        reset = 1'b1;
        total++;
        if (pop[0] !== 1'b0) begin
            bad++;
            $display("FAIL pop_at_release: got %b need 0", pop[0]);
        end
        @(negedge clock);
        total++;
        if (pop[0] !== 1'b1) begin
            bad++;
            $display("FAIL pop_first_edge: got %b need 1", pop[0]);
        end
    endtask

    task automatic test_single_frame();
        @(negedge clock);
        total++;
        if (pop[0] !== 1'b0 || line[0] !== 1'b1) begin
            bad++;
            $display("FAIL pop_width: pop=%b line=%b need 0 1", pop[0], line[0]);
        end
        @(negedge clock);
        total++;
        if (line[0] !== 1'b0) begin
            bad++;
            $display("FAIL start_latency: line=%b need 0", line[0]);
        end
        rx_frame("frame_a5", -1);
        check_busy_falls("frame_a5");
        total++;
        if (pop_cnt[0] !== 1) begin
            bad++;
            $display("FAIL single_pop_count: got %0d need 1", pop_cnt[0]);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        int hi;
        p0 = pop_cnt[0];
        push_byte(8'h00);
        push_byte(8'hFF);
        rx_frame("b2b_00", -1);
        hi = 0;
        @(negedge clock);
        while (line[0] === 1'b1 && hi < 50) begin
            hi++;
            @(negedge clock);
        end
        total++;
        if (CPB + hi != 6) begin
            bad++;
            $display("FAIL b2b_gap: high for %0d clocks need 6", CPB + hi);
        end
        rx_frame("b2b_ff", -1);
        check_busy_falls("b2b_ff");
        repeat (20) @(negedge clock);
        total++;
        if (pop_cnt[0] - p0 !== 2) begin
            bad++;
            $display("FAIL b2b_pops: got %0d need 2", pop_cnt[0] - p0);
        end
    endtask

    task automatic test_parity();
        en  = 3'b000;
        sel = 1;
        en  = 3'b010;
        push_byte(8'h07);
        rx_frame("par_even_07", -1);
        check_busy_falls("par_even_07");
        en  = 3'b000;
        sel = 2;
        en  = 3'b100;
        push_byte(8'h07);
        push_byte(8'h81);
        rx_frame("par_odd_07", -1);
        rx_frame("par_odd_81", -1);
        check_busy_falls("par_odd_81");
        en  = 3'b000;
        sel = 0;
    endtask

    task automatic test_enable_gate();
        int p0;
        p0 = pop_cnt[0];
        en = 3'b000;
        push_byte(8'h3C);
        push_byte(8'h81);
        repeat (100) @(negedge clock);
        total++;
        if (pop_cnt[0] !== p0 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL enable_low: pops=%0d busy=%b need 0 0", pop_cnt[0] - p0, busy[0]);
        end
        en[0] = 1'b1;
        rx_frame("gate_3c", 3);
        check_busy_falls("gate_3c");
        repeat (40) @(negedge clock);
        total++;
        if (pop_cnt[0] - p0 !== 1 || line[0] !== 1'b1) begin
            bad++;
            $display("FAIL enable_drop: pops=%0d line=%b need 1 1", pop_cnt[0] - p0, line[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int p0;
        en[0] = 1'b1;
        n = 0;
        while (line[0] !== 1'b0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (line[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_start timeout: line=%b need 0", line[0]);
        end
        repeat (4 * CPB + 1) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        total++;
        if (line[0] !== 1'b1 || busy[0] !== 1'b0 || pop[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: line=%b busy=%b pop=%b need 1 0 0", line[0], busy[0], pop[0]);
        end
        repeat (10) void'(sb.pop_front());
        push_byte(8'h5A);
        p0 = pop_cnt[0];
        repeat (3) @(negedge clock);
        total++;
        if (pop_cnt[0] !== p0 || line[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_hold: pops=%0d line=%b need 0 1", pop_cnt[0] - p0, line[0]);
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (pop[0] !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_pop: got %b need 1", pop[0]);
        end
        rx_frame("post_reset_5a", -1);
        check_busy_falls("post_reset_5a");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity();
        test_enable_gate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
